// File: rtl/vdp1_erase_engine.sv
// vdp1_erase_engine
//   Framebuffer erase engine. Software loads the erase colour (EWDR) and the
//   window corners (EWLR = upper-left, EWRR = lower-right) into shadow
//   registers; START copies them into an active job, which then fills the
//   window in raster order with FB_REQ/FB_ACK write beats.
//
//   Handshake: FB_REQ is valid, FB_ACK is ready. A beat transfers on a rising
//   MCLK edge where both are high. While FB_REQ is high and FB_ACK is low,
//   FB_ADDR and FB_WDATA hold their values; FB_REQ never drops without a
//   transfer.
//
//   Optional build macro: VDP1_ERASE_CLIP_EN clamps the latched window to the
//   framebuffer (X end <= FB_W, Y end <= FB_H-1).
//
// Ports
//   MCLK, RESET          clock, asynchronous active-high reset
//   REG_WE/ADDR/WDATA    shadow register write (0=EWDR, 1=EWLR, 2=EWRR)
//   START, ABORT         single-cycle job trigger / stop request
//   BUSY, DONE           job active / one-cycle end-of-job pulse
//   FB_REQ, FB_ACK       write-beat valid / accepted
//   FB_ADDR, FB_WDATA    pixel address of first pixel / replicated colour
//   DBG_STATE            current FSM state (0=IDLE, 1=RUN, 2=FIN)
module vdp1_erase_engine #(
   parameter int FB_W         = 512,
   parameter int FB_H         = 256,
   parameter int PIX_PER_BEAT = 1,
   parameter int ADDR_W       = 18
) (
   input  logic                       MCLK,
   input  logic                       RESET,
   input  logic                       REG_WE,
   input  logic [1:0]                 REG_ADDR,
   input  logic [15:0]                REG_WDATA,
   input  logic                       START,
   input  logic                       ABORT,
   output logic                       BUSY,
   output logic                       DONE,
   output logic                       FB_REQ,
   input  logic                       FB_ACK,
   output logic [ADDR_W-1:0]          FB_ADDR,
   output logic [16*PIX_PER_BEAT-1:0] FB_WDATA,
   output logic [1:0]                 DBG_STATE
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   // X coordinates need 11 bits: window edges reach 1016 and x+step reaches 1024.
   localparam logic [10:0] PIX_STEP = 11'(PIX_PER_BEAT);

   state_t      state_q, state_d;
   logic [15:0] ewdr_q, ewlr_q, ewrr_q;
   logic [15:0] data_q, data_d;
   logic [10:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d;
   logic [8:0]  ye_q, ye_d, y_q, y_d;
   logic        empty_q, empty_d;
   logic        abort_q, abort_d;

   logic [10:0] win_xs, win_xe, lat_xe, x_next;
   logic [8:0]  win_ys, win_ye, lat_ye;
   logic        lat_empty, line_end, last_beat;

   // Shadow registers accept writes in every state; the job runs from copies.
   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         ewdr_q <= '0;
         ewlr_q <= '0;
         ewrr_q <= '0;
      end else if (REG_WE) begin
         case (REG_ADDR)
            2'd0:    ewdr_q <= REG_WDATA;
            2'd1:    ewlr_q <= REG_WDATA;
            2'd2:    ewrr_q <= REG_WDATA;
            default: ;
         endcase
      end
   end

   // Window decode: X in units of 8 pixels from bits [15:9], Y from [8:0].
   assign win_xs = {1'b0, ewlr_q[15:9], 3'b000};
   assign win_xe = {1'b0, ewrr_q[15:9], 3'b000};
   assign win_ys = ewlr_q[8:0];
   assign win_ye = ewrr_q[8:0];

`ifdef VDP1_ERASE_CLIP_EN
   localparam logic [10:0] X_LIMIT = 11'(FB_W);
   localparam logic [8:0]  Y_LIMIT = 9'(FB_H - 1);
   assign lat_xe = (win_xe > X_LIMIT) ? X_LIMIT : win_xe;
   assign lat_ye = (win_ye > Y_LIMIT) ? Y_LIMIT : win_ye;
`else
   assign lat_xe = win_xe;
   assign lat_ye = win_ye;
`endif

   // Emptiness is decided once at latch time so RUN only needs one flag.
   assign lat_empty = (win_xs >= lat_xe) || (win_ys > lat_ye);

   assign x_next    = x_q + PIX_STEP;
   assign line_end  = (x_next >= xe_q);
   assign last_beat = line_end && (y_q == ye_q);

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         xs_q    <= '0;
         xe_q    <= '0;
         ye_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         empty_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         xs_q    <= xs_d;
         xe_q    <= xe_d;
         ye_q    <= ye_d;
         x_q     <= x_d;
         y_q     <= y_d;
         empty_q <= empty_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      xs_d    = xs_q;
      xe_d    = xe_q;
      ye_d    = ye_q;
      x_d     = x_q;
      y_d     = y_q;
      empty_d = empty_q;
      abort_d = abort_q;
      case (state_q)
         S_IDLE: begin
            // START wins over ABORT here; ABORT alone is ignored in IDLE.
            if (START) begin
               state_d = S_RUN;
               data_d  = ewdr_q;
               xs_d    = win_xs;
               xe_d    = lat_xe;
               ye_d    = lat_ye;
               x_d     = win_xs;
               y_d     = win_ys;
               empty_d = lat_empty;
               abort_d = 1'b0;
            end
         end
         S_RUN: begin
            if (empty_q) begin
               state_d = S_FIN;
            end else if (FB_ACK) begin
               // FB_REQ is always high in a non-empty RUN, so ACK is a transfer.
               if (last_beat || abort_q || ABORT) begin
                  state_d = S_FIN;
               end else if (line_end) begin
                  x_d = xs_q;
                  y_d = y_q + 9'd1;
               end else begin
                  x_d = x_next;
               end
            end else if (ABORT) begin
               // The pending beat must still complete before stopping.
               abort_d = 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
            abort_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign BUSY      = (state_q == S_RUN);
   assign DONE      = (state_q == S_FIN);
   assign FB_REQ    = (state_q == S_RUN) && !empty_q;
   assign FB_ADDR   = ADDR_W'(y_q) * ADDR_W'(FB_W) + ADDR_W'(x_q);
   assign FB_WDATA  = {PIX_PER_BEAT{data_q}};
   assign DBG_STATE = state_q;

endmodule
